// File: rtl/q4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : q4_pkg
//  Description : Shared definitions for the q4 memory-access stage: access
//                size encodings (funct3), FSM state type, control width.
//  Revision    : 1.0 - initial release
// ============================================================================
package q4_pkg;

    localparam int CTRL_WIDTH_DEFAULT = 16;

    // funct3 access-size encodings; the 1xx forms exist for loads only
    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    // Bus transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/q4_mem_access_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational load/store alignment: byte enables and store
//                lane steering, misalign/illegal detection, load lane select
//                with sign or zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import q4_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Store side: byte enables, replicated write data and access legality
    always_comb begin
        be         = 4'b0000;
        wdata      = store_data;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_BYTE, F3_BYTEU: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{store_data[7:0]}};
            end
            F3_HALF, F3_HALFU: begin
                be         = 4'b0011 << {byte_off[1], 1'b0};
                wdata      = {2{store_data[15:0]}};
                misaligned = byte_off[0];
            end
            F3_WORD: begin
                be         = 4'b1111;
                misaligned = |byte_off;
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants are meaningless for stores
        if (is_store && funct3[2]) begin
            illegal = 1'b1;
        end
    end

    // Load side: pick the addressed lane, then extend to 32 bits
    always_comb begin
        case (byte_off)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_BYTE:  load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BYTEU: load_data = {24'd0, lane_byte};
            F3_HALF:  load_data = {{16{lane_half[15]}}, lane_half};
            F3_HALFU: load_data = {16'd0, lane_half};
            F3_WORD:  load_data = rdata;
            default:  load_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/q4_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : q4_mem_access
//  Description : Memory-access pipeline stage. Issues loads/stores on a
//                req/gnt/rvalid bus, stalls upstream while a transaction is
//                outstanding, and registers results toward writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module q4_mem_access
    import q4_pkg::*;
#(
    parameter int CTRL_WIDTH = CTRL_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc_next_i,
    input  logic [31:0]           alu_out_i,
    input  logic [31:0]           reg_rd_data2_i,
    input  logic [4:0]            reg_wr_port_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_q4_i,
    input  logic                  mem_rd_i,
    input  logic                  mem_wr_i,
    input  logic [2:0]            funct3_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [31:0]           dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [31:0]           dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [31:0]           dmem_rdata_i,
    output logic                  stall_o,
    output logic [31:0]           pc_next_o,
    output logic [31:0]           alu_out_o,
    output logic [31:0]           mem_data_o,
    output logic [4:0]            reg_wr_port_o,
    output logic [CTRL_WIDTH-1:0] ctrl_q4_o,
    output logic                  fault_o
);

    state_t      state;
    state_t      state_next;
    logic        memop;
    logic        is_store;
    logic        is_load;
    logic        misaligned;
    logic        illegal;
    logic        fault;
    logic        req;
    logic        complete;
    logic        stall;
    logic [31:0] load_data;

    // A store wins when both load and store are flagged
    assign memop    = mem_rd_i | mem_wr_i;
    assign is_store = mem_wr_i;
    assign is_load  = mem_rd_i & ~mem_wr_i;
    assign fault    = memop & (misaligned | illegal);

    lsu_align u_align (
        .byte_off   (alu_out_i[1:0]),
        .funct3     (funct3_i),
        .is_store   (is_store),
        .store_data (reg_rd_data2_i),
        .rdata      (dmem_rdata_i),
        .be         (dmem_be_o),
        .wdata      (dmem_wdata_o),
        .misaligned (misaligned),
        .illegal    (illegal),
        .load_data  (load_data)
    );

    assign dmem_we_o   = mem_wr_i;
    assign dmem_addr_o = {alu_out_i[31:2], 2'b00};

    // Request and stall are forced low while reset is asserted
    assign stall      = memop & ~fault & ~complete;
    assign dmem_req_o = rst_n & req;
    assign stall_o    = rst_n & stall;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state, bus request and transaction completion
    always_comb begin
        state_next = state;
        req        = 1'b0;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memop && !fault) begin
                    req = 1'b1;
                    if (dmem_gnt_i) begin
                        if (is_store) begin
                            complete = 1'b1;
                        end else begin
                            state_next = ST_RESP;
                        end
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (dmem_gnt_i) begin
                    if (is_store) begin
                        complete   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                // gnt is meaningless here; only the read response matters
                if (dmem_rvalid_i) begin
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory-to-writeback register: bubble while stalled, squash on fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next_o     <= 32'd0;
            alu_out_o     <= 32'd0;
            mem_data_o    <= 32'd0;
            reg_wr_port_o <= 5'd0;
            ctrl_q4_o     <= '0;
            fault_o       <= 1'b0;
        end else if (stall) begin
            pc_next_o     <= 32'd0;
            alu_out_o     <= 32'd0;
            mem_data_o    <= 32'd0;
            reg_wr_port_o <= 5'd0;
            ctrl_q4_o     <= '0;
            fault_o       <= 1'b0;
        end else if (fault) begin
            pc_next_o     <= pc_next_i;
            alu_out_o     <= alu_out_i;
            mem_data_o    <= 32'd0;
            reg_wr_port_o <= 5'd0;
            ctrl_q4_o     <= '0;
            fault_o       <= 1'b1;
        end else begin
            pc_next_o     <= pc_next_i;
            alu_out_o     <= alu_out_i;
            mem_data_o    <= is_load ? load_data : 32'd0;
            reg_wr_port_o <= reg_wr_port_i;
            ctrl_q4_o     <= ctrl_q4_i;
            fault_o       <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_q4_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_q4_mem_access
//  Description : Self-checking bench for q4_mem_access: directed scenarios
//                plus randomized loads/stores/ALU ops against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_q4_mem_access;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   pc_next_i = '0;
    logic [31:0]   alu_out_i = '0;
    logic [31:0]   reg_rd_data2_i = '0;
    logic [4:0]    reg_wr_port_i = '0;
    logic [CW-1:0] ctrl_q4_i = '0;
    logic          mem_rd_i = 1'b0;
    logic          mem_wr_i = 1'b0;
    logic [2:0]    funct3_i = '0;
    logic          dmem_req_o;
    logic          dmem_we_o;
    logic [31:0]   dmem_addr_o;
    logic [3:0]    dmem_be_o;
    logic [31:0]   dmem_wdata_o;
    logic          dmem_gnt_i = 1'b0;
    logic          dmem_rvalid_i = 1'b0;
    logic [31:0]   dmem_rdata_i = '0;
    logic          stall_o;
    logic [31:0]   pc_next_o;
    logic [31:0]   alu_out_o;
    logic [31:0]   mem_data_o;
    logic [4:0]    reg_wr_port_o;
    logic [CW-1:0] ctrl_q4_o;
    logic          fault_o;

    int total = 0;
    int bad   = 0;

    q4_mem_access #(.CTRL_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_next_i      (pc_next_i),
        .alu_out_i      (alu_out_i),
        .reg_rd_data2_i (reg_rd_data2_i),
        .reg_wr_port_i  (reg_wr_port_i),
        .ctrl_q4_i      (ctrl_q4_i),
        .mem_rd_i       (mem_rd_i),
        .mem_wr_i       (mem_wr_i),
        .funct3_i       (funct3_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .stall_o        (stall_o),
        .pc_next_o      (pc_next_o),
        .alu_out_o      (alu_out_o),
        .mem_data_o     (mem_data_o),
        .reg_wr_port_o  (reg_wr_port_o),
        .ctrl_q4_o      (ctrl_q4_o),
        .fault_o        (fault_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit model_fault(input bit ld, input bit st, input logic [2:0] f3,
                                       input logic [31:0] addr);
        int off;
        if (!(ld || st)) return 1'b0;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (st && f3[2]) return 1'b1;
        off = int'(addr[1:0]);
        return (off % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [7:0] m;
        m = ((8'd1 << nbytes(f3)) - 8'd1) << addr[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (nbytes(f3))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        int n;
        n    = nbytes(f3);
        v    = rd >> (8 * int'(addr[1:0]));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = v & mask;
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // One instruction: g = cycles of request before gnt, r = cycles from gnt to rvalid
    task automatic run_instr(input bit ld, input bit st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int g, input int r,
                             input bit noise);
        bit          flt;
        bit          reqs;
        bit          store;
        bit          load;
        int          done;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [CW-1:0] ctrl;
        flt   = model_fault(ld, st, f3, addr);
        store = st;
        load  = ld && !st;
        reqs  = (ld || st) && !flt;
        done  = !reqs ? 0 : (store ? g : g + r);
        pc    = $urandom;
        rd    = 5'($urandom);
        ctrl  = CW'($urandom);
        for (int c = 0; c <= done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                pc_next_i      = pc;
                alu_out_i      = addr;
                reg_rd_data2_i = sdata;
                reg_wr_port_i  = rd;
                ctrl_q4_i      = ctrl;
                mem_rd_i       = ld;
                mem_wr_i       = st;
                funct3_i       = f3;
            end
            if (reqs && c <= g) dmem_gnt_i = (c == g);
            else                dmem_gnt_i = noise ? 1'($urandom) : 1'b0;
            if (reqs && load) begin
                if (c == g + r) dmem_rvalid_i = 1'b1;
                else if (c <= g) dmem_rvalid_i = noise ? 1'($urandom) : 1'b0;
                else dmem_rvalid_i = 1'b0;
            end else begin
                dmem_rvalid_i = noise ? 1'($urandom) : 1'b0;
            end
            dmem_rdata_i = (c == done) ? rdata : $urandom;
            #1;
            chk("req", 32'(dmem_req_o), 32'(reqs && c <= g));
            chk("stall", 32'(stall_o), 32'(reqs && c < done));
            if (reqs && c <= g) begin
                chk("we", 32'(dmem_we_o), 32'(store));
                chk("addr", dmem_addr_o, {addr[31:2], 2'b00});
                chk("be", 32'(dmem_be_o), 32'(model_be(f3, addr)));
                if (store) chk("wdata", dmem_wdata_o, model_wdata(f3, sdata));
            end
            @(posedge clk);
            #1;
            if (c < done) begin
                chk("bubble_ctrl", 32'(ctrl_q4_o), 32'd0);
                chk("bubble_rd", 32'(reg_wr_port_o), 32'd0);
                chk("bubble_fault", 32'(fault_o), 32'd0);
            end else begin
                chk("fault_o", 32'(fault_o), 32'(flt));
                chk("ctrl_o", 32'(ctrl_q4_o), flt ? 32'd0 : 32'(ctrl));
                chk("rd_o", 32'(reg_wr_port_o), flt ? 32'd0 : 32'(rd));
                if (!flt) begin
                    chk("pc_o", pc_next_o, pc);
                    chk("alu_o", alu_out_o, addr);
                    chk("mem_data", mem_data_o, (reqs && load) ? model_load(f3, addr, rdata) : 32'd0);
                end
            end
        end
    endtask

    initial begin
        int kind;
        bit ld;
        bit st;
        logic [31:0] addr;

        // Reset: request/stall gated even with a load presented
        mem_rd_i = 1'b1;
        funct3_i = 3'b010;
        dmem_gnt_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_ctrl", 32'(ctrl_q4_o), 32'd0);
        chk("rst_alu", alu_out_o, 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        @(negedge clk);
        mem_rd_i   = 1'b0;
        dmem_gnt_i = 1'b0;
        rst_n      = 1'b1;

        // Directed scenarios
        run_instr(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 0, 1, 1'b0); // ADD
        run_instr(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 1, 1'b0); // SW
        run_instr(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3, 1, 1'b0); // LB
        run_instr(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3, 1, 1'b0); // LBU
        run_instr(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 0, 1, 1'b0); // SH
        run_instr(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 1, 1'b0); // LW misaligned

        // Reset while waiting for the read response
        @(negedge clk);
        pc_next_i = 32'h0000_0404; alu_out_i = 32'h0000_0200; reg_wr_port_i = 5'd7;
        ctrl_q4_i = 16'h5A5A; mem_rd_i = 1'b1; mem_wr_i = 1'b0; funct3_i = 3'b010;
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(dmem_req_o), 32'd0);
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_ctrl", 32'(ctrl_q4_o), 32'd0);
        chk("midrst_data", mem_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rd_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_gnt_i = 1'b1;
        dmem_rdata_i = 32'hFFFF_FFFF;
        #1;
        chk("late_rvalid_stall", 32'(stall_o), 32'd0);
        chk("late_rvalid_req", 32'(dmem_req_o), 32'd0);
        @(posedge clk);
        #1;
        chk("late_rvalid_data", mem_data_o, 32'd0);
        chk("late_rvalid_rd", 32'(reg_wr_port_o), 32'd7);
        // A fresh load must wait for its own response
        run_instr(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 1, 2, 1'b1);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 9));
            ld   = (kind >= 3 && kind <= 6) || kind == 9;
            st   = kind >= 7;
            addr = $urandom;
            run_instr(ld, st, 3'($urandom), addr, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
